// File: rtl/bin2bcd_seq_display.sv
// Iterative double-dabble binary-to-BCD converter with seven-segment decode.
// Optional leading-zero blanking: define BIN2BCD_LZ_BLANK_EN.
module bin2bcd_seq_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hex_mode,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   segments
);

  localparam int AW  = 4 * DIGITS;
  localparam int CW  = $clog2(WIDTH + 1);
  // 2^W is never a power of ten, so digits(2^W-1) = floor(W*log10(2))+1
  localparam int DEC = (WIDTH * 30103) / 100000 + 1;
  localparam int HEX = (WIDTH + 3) / 4;

  generate
    if (WIDTH < 1 || DIGITS < DEC || DIGITS < HEX) begin : g_bad_cfg
      $error("bin2bcd_seq_display: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hex_q, hex_d;
  logic [AW-1:0]    bcd_q, bcd_d;
  logic             done_q, done_d;
  logic             blank_q, blank_d;
  logic [AW-1:0]    adj;
  logic [AW-1:0]    shifted;
  logic [AW-1:0]    hexv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= 1'b0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
      blank_q <= blank_d;
    end
  end

  always_comb begin
    state_d = state;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    blank_d = blank_q;
    adj     = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj[AW-2:0], sh_q[WIDTH-1]};
    hexv = '0;
    hexv[WIDTH-1:0] = sh_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          sh_d    = bin;
          hex_d   = hex_mode;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (hex_q) begin
          bcd_d   = hexv;
          done_d  = 1'b1;
          blank_d = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d = shifted;
          sh_d  = sh_q << 1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_d   = shifted;
            done_d  = 1'b1;
            blank_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

`ifdef BIN2BCD_LZ_BLANK_EN
  logic lead;

  // Scan from the top; fields stay dark until the first non-zero digit.
  always_comb begin
    segments = '1;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0 || i == 0) begin
        lead = 1'b0;
      end
      if (!blank_q && !lead) begin
        segments[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
      end
    end
  end
`else
  always_comb begin
    segments = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!blank_q) begin
        segments[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
      end
    end
  end
`endif

  assign busy = (state == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
